// File: rtl/dds_log_pkg.sv
// Shared types and helpers for the DDS sample logger: FSM states and the 40-bit capture record.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dds_log_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DUMP    = 2'd2
    } state_e;

    localparam int REC_BYTES = 5;
    localparam int REC_W     = 40;

    // Field order is the wire order: the MSB byte goes out first.
    typedef struct packed {
        logic [15:0] sine;
        logic        pwm_2;
        logic        pwm_1;
        logic [4:0]  rsvd;
        logic        tri_hi;
        logic [15:0] tri_lo;
    } rec_t;

    function automatic logic [REC_W-1:0] pack_record(
        input logic [15:0] sine,
        input logic [16:0] tri_v,
        input logic        p1,
        input logic        p2
    );
        rec_t r;
        r.sine   = sine;
        r.pwm_2  = p2;
        r.pwm_1  = p1;
        r.rsvd   = '0;
        r.tri_hi = tri_v[16];
        r.tri_lo = tri_v[15:0];
        return r;
    endfunction

endpackage

// File: rtl/dds_log_ram.sv
// Simple dual-port record store, DEPTH x REC_W, one write port and one read port.
// Latency: read data valid one cycle after rd_en.
// Backpressure: none; caller owns the read schedule.
module dds_log_ram
    import dds_log_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [REC_W-1:0]  wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [REC_W-1:0]  rd_dat
);

    logic [REC_W-1:0] mem [DEPTH];
    logic [REC_W-1:0] rd_dat_q;

    // No reset here so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat_q <= mem[rd_addr];
        end
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/dds_sample_logger.sv
// Captures a decimated DEPTH-record window of DDS outputs, then streams it out as 5 bytes per record.
// Latency: first byte valid 2 cycles after dump entry, then one byte per cycle while m_ready is high.
// Backpressure: m_valid/m_data/m_last hold while m_ready is low; next record is prefetched meanwhile.
module dds_sample_logger
    import dds_log_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        arm,
    input  logic [7:0]  decim,
    input  logic [15:0] sine_in,
    input  logic [16:0] tri_in,
    input  logic        pwm_1,
    input  logic        pwm_2,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic        busy,
    output logic        done
);

    localparam logic [ADDR_W:0]   NUM_REC   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   LAST_REC  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        LAST_BYTE = 3'(REC_BYTES - 1);

    state_e             state_q, state_d;
    logic [7:0]         decim_q, decim_d;
    logic [7:0]         dec_cnt_q, dec_cnt_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [ADDR_W:0]    rd_addr_q, rd_addr_d;
    logic [ADDR_W:0]    ld_cnt_q, ld_cnt_d;
    logic               rd_pend_q, rd_pend_d;
    logic               pf_vld_q, pf_vld_d;
    logic [REC_W-1:0]   pf_dat_q, pf_dat_d;
    logic [REC_W-1:0]   sh_q, sh_d;
    logic [2:0]         byte_idx_q, byte_idx_d;
    logic               sh_last_q, sh_last_d;
    logic               m_valid_q, m_valid_d;
    logic               m_last_q, m_last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               wr_en;
    logic               rd_en;
    logic [REC_W-1:0]   wr_dat;
    logic [REC_W-1:0]   rd_dat;
    logic               xfer;
    logic               last_beat;
    logic               load_sh;

    assign wr_dat = pack_record(sine_in, tri_in, pwm_1, pwm_2);

    dds_log_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_q),
        .wr_dat  (wr_dat),
        .rd_en   (rd_en),
        .rd_addr (rd_addr_q[ADDR_W-1:0]),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        state_d    = state_q;
        decim_d    = decim_q;
        dec_cnt_d  = dec_cnt_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        ld_cnt_d   = ld_cnt_q;
        rd_pend_d  = rd_pend_q;
        pf_vld_d   = pf_vld_q;
        pf_dat_d   = pf_dat_q;
        sh_d       = sh_q;
        byte_idx_d = byte_idx_q;
        sh_last_d  = sh_last_q;
        m_valid_d  = m_valid_q;
        done_d     = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;

        xfer      = m_valid_q && m_ready;
        last_beat = xfer && (byte_idx_q == LAST_BYTE);
        // Shifter takes a new record when empty or as its final byte leaves.
        load_sh   = (state_q == ST_DUMP) && (!m_valid_q || last_beat) &&
                    (pf_vld_q || rd_pend_q);

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d    = ST_CAPTURE;
                    decim_d    = decim;
                    dec_cnt_d  = 8'd0;
                    wr_addr_d  = '0;
                    rd_addr_d  = '0;
                    ld_cnt_d   = '0;
                    rd_pend_d  = 1'b0;
                    pf_vld_d   = 1'b0;
                    byte_idx_d = 3'd0;
                    sh_last_d  = 1'b0;
                end
            end

            ST_CAPTURE: begin
                dec_cnt_d = (dec_cnt_q == decim_q) ? 8'd0 : dec_cnt_q + 8'd1;
                if (dec_cnt_q == 8'd0) begin
                    wr_en     = 1'b1;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = ST_DUMP;
                    end
                end
            end

            ST_DUMP: begin
                // At most one record in flight: either in the RAM pipe or parked in pf.
                rd_pend_d = 1'b0;
                if ((rd_addr_q != NUM_REC) && !rd_pend_q && !pf_vld_q) begin
                    rd_en     = 1'b1;
                    rd_pend_d = 1'b1;
                    rd_addr_d = rd_addr_q + (ADDR_W+1)'(1);
                end

                if (load_sh) begin
                    sh_d       = pf_vld_q ? pf_dat_q : rd_dat;
                    pf_vld_d   = 1'b0;
                    byte_idx_d = 3'd0;
                    sh_last_d  = (ld_cnt_q == LAST_REC);
                    ld_cnt_d   = ld_cnt_q + (ADDR_W+1)'(1);
                    m_valid_d  = 1'b1;
                end else begin
                    if (rd_pend_q) begin
                        pf_vld_d = 1'b1;
                        pf_dat_d = rd_dat;
                    end
                    if (last_beat) begin
                        m_valid_d = 1'b0;
                        sh_d      = '0;
                    end else if (xfer) begin
                        sh_d       = sh_q << 8;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end

                if (xfer && m_last_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        m_last_d = m_valid_d && sh_last_d && (byte_idx_d == LAST_BYTE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            decim_q    <= 8'd0;
            dec_cnt_q  <= 8'd0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            ld_cnt_q   <= '0;
            rd_pend_q  <= 1'b0;
            pf_vld_q   <= 1'b0;
            pf_dat_q   <= '0;
            sh_q       <= '0;
            byte_idx_q <= 3'd0;
            sh_last_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            decim_q    <= decim_d;
            dec_cnt_q  <= dec_cnt_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            ld_cnt_q   <= ld_cnt_d;
            rd_pend_q  <= rd_pend_d;
            pf_vld_q   <= pf_vld_d;
            pf_dat_q   <= pf_dat_d;
            sh_q       <= sh_d;
            byte_idx_q <= byte_idx_d;
            sh_last_q  <= sh_last_d;
            m_valid_q  <= m_valid_d;
            m_last_q   <= m_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign m_data  = sh_q[REC_W-1 -: 8];
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_dds_sample_logger.sv
// Scoreboard bench for dds_sample_logger at DEPTH=4: stimulus pushes expected bytes, a monitor pops them.
module tb_dds_sample_logger;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        arm = 1'b0;
    logic [7:0]  decim = 8'd0;
    logic [15:0] sine_in = 16'd0;
    logic [16:0] tri_in = 17'd0;
    logic        pwm_1 = 1'b0;
    logic        pwm_2 = 1'b0;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic        m_last;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    dds_sample_logger #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .arm     (arm),
        .decim   (decim),
        .sine_in (sine_in),
        .tri_in  (tri_in),
        .pwm_1   (pwm_1),
        .pwm_2   (pwm_2),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .busy    (busy),
        .done    (done)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int c0 = 0;
    logic [8:0] exp_q[$];

    int   tx_cnt = 0;
    int   first_vld_cyc = -1000;
    int   last_tx_cyc = 0;
    bit   seen_vld = 0;
    bit   exp_done = 0;
    bit   win_done = 0;
    bit   hold_vld = 0;
    bit   rdy_rand = 0;
    logic [7:0] hold_dat;
    logic       hold_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Expected bytes straight from the record byte layout B0..B4.
    task automatic push_rec(input logic [15:0] s, input logic [16:0] t,
                            input logic p1, input logic p2, input bit last);
        exp_q.push_back({1'b0, s[15:8]});
        exp_q.push_back({1'b0, s[7:0]});
        exp_q.push_back({1'b0, p2, p1, 5'b00000, t[16]});
        exp_q.push_back({1'b0, t[15:8]});
        exp_q.push_back({last, t[7:0]});
    endtask

    task automatic push_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4, input bit last);
        exp_q.push_back({1'b0, b0});
        exp_q.push_back({1'b0, b1});
        exp_q.push_back({1'b0, b2});
        exp_q.push_back({1'b0, b3});
        exp_q.push_back({last, b4});
    endtask

    task automatic set_inputs(input int mode, input int k);
        case (mode)
            0: begin
                sine_in = 16'(k); tri_in = 17'(-k); pwm_1 = 1'b0; pwm_2 = 1'b0;
            end
            1: begin
                sine_in = 16'(16'h0A00 + k * 257); tri_in = 17'(k * 3 - 5);
                pwm_1 = k[3]; pwm_2 = k[2];
            end
            default: begin
                sine_in = 16'h8000; tri_in = 17'h10000; pwm_1 = 1'b1; pwm_2 = 1'b0;
            end
        endcase
    endtask

    task automatic start_win(input logic [7:0] d);
        tx_cnt = 0;
        seen_vld = 0;
        win_done = 0;
        first_vld_cyc = -1000;
        @(posedge clk); #1;
        decim = d;
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
        c0 = cyc;
        chk("busy_rise", busy, 1);
    endtask

    task automatic capture(input logic [7:0] d, input int mode, input bit push, input bit arm_mid);
        int step;
        step = int'(d) + 1;
        for (int k = 0; k <= (DEPTH - 1) * step; k++) begin
            set_inputs(mode, k);
            if (push && (k % step == 0))
                push_rec(sine_in, tri_in, pwm_1, pwm_2, (k / step) == DEPTH - 1);
            arm = arm_mid && (k == 1);
            @(posedge clk); #1;
        end
        arm = 1'b0;
    endtask

    task automatic wait_win(input string name);
        int n;
        n = 0;
        while (!win_done && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (!win_done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: window not finished after %0d cycles, %0d bytes seen", name, n, tx_cnt);
        end
    endtask

    task automatic chk_latency(input string name, input logic [7:0] d);
        int entry;
        int lat;
        entry = (DEPTH - 1) * (int'(d) + 1) + 1;
        lat = first_vld_cyc - c0;
        checks++;
        if (lat < entry + 1 || lat > entry + 2) begin
            errors++;
            $display("FAIL %s_first_valid: first m_valid %0d cycles after capture start, required %0d..%0d",
                     name, lat, entry + 1, entry + 2);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            m_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                hold_vld = 0;
                exp_done = 0;
            end else begin
                if (exp_done) begin
                    chk("done_pulse_busy_low", {done, busy}, 2'b10);
                    exp_done = 0;
                    win_done = 1;
                end else if (done) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: done=1 at cycle %0d, required 0", cyc);
                end
                if (hold_vld) begin
                    chk("stall_hold", {m_valid, m_last, m_data}, {1'b1, hold_last, hold_dat});
                    hold_vld = 0;
                end
                if (m_valid && !seen_vld) begin
                    seen_vld = 1;
                    first_vld_cyc = cyc;
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte: got %02h last=%0b, no byte expected", m_data, m_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("byte%0d_last_data", tx_cnt), {23'd0, m_last, m_data}, {23'd0, e});
                    end
                    if (m_last) exp_done = 1;
                    tx_cnt++;
                    last_tx_cyc = cyc;
                end else if (m_valid) begin
                    hold_vld = 1;
                    hold_dat = m_data;
                    hold_last = m_last;
                end
            end
        end
    end

    initial begin
        int n;
        // Reset state
        #2 resetn = 1'b0;
        #1 chk("reset_outputs", {m_valid, m_last, busy, done, m_data}, 12'd0);
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        chk("idle_busy", busy, 0);

        // Ramp, decim=0, hand-computed records
        push_bytes(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        push_bytes(8'h00, 8'h01, 8'h01, 8'hFF, 8'hFF, 0);
        push_bytes(8'h00, 8'h02, 8'h01, 8'hFF, 8'hFE, 0);
        push_bytes(8'h00, 8'h03, 8'h01, 8'hFF, 8'hFD, 1);
        start_win(8'd0);
        capture(8'd0, 0, 0, 0);
        wait_win("ramp");
        chk("ramp_bytes", tx_cnt, 5 * DEPTH);
        chk_latency("ramp", 8'd0);
        chk("ramp_throughput", last_tx_cyc - first_vld_cyc, 5 * DEPTH - 1);

        // decim=3: samples at capture cycles 0,4,8,12
        start_win(8'd3);
        capture(8'd3, 1, 1, 0);
        wait_win("decim3");
        chk("decim3_bytes", tx_cnt, 5 * DEPTH);
        chk_latency("decim3", 8'd3);
        chk("decim3_throughput", last_tx_cyc - first_vld_cyc, 5 * DEPTH - 1);

        // Random backpressure
        rdy_rand = 1;
        start_win(8'd1);
        capture(8'd1, 1, 1, 0);
        wait_win("backpressure");
        chk("backpressure_bytes", tx_cnt, 5 * DEPTH);
        rdy_rand = 0;

        // arm during CAPTURE and DUMP is ignored
        start_win(8'd0);
        capture(8'd0, 1, 1, 1);
        n = 0;
        while (tx_cnt < 3 && n < 100) begin @(posedge clk); n++; end
        #1 arm = 1'b1;
        @(posedge clk); #1 arm = 1'b0;
        wait_win("arm_ignored");
        repeat (3) @(posedge clk);
        #1;
        chk("arm_ignored_no_restart", busy, 0);
        chk("arm_ignored_bytes", tx_cnt, 5 * DEPTH);

        // Reset mid-DUMP aborts without done
        start_win(8'd0);
        capture(8'd0, 1, 1, 0);
        n = 0;
        while (tx_cnt < 7 && n < 100) begin @(posedge clk); n++; end
        #3 resetn = 1'b0;
        #1 chk("abort_outputs", {m_valid, m_last, busy, done, m_data}, 12'd0);
        exp_q.delete();
        @(posedge clk); @(posedge clk); #1;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("abort_stays_idle", {busy, m_valid}, 2'b00);
        start_win(8'd0);
        capture(8'd0, 0, 1, 0);
        wait_win("after_abort");
        chk("after_abort_bytes", tx_cnt, 5 * DEPTH);

        // Extreme values, hand-computed record 80 00 41 00 00
        for (int r = 0; r < DEPTH; r++)
            push_bytes(8'h80, 8'h00, 8'h41, 8'h00, 8'h00, r == DEPTH - 1);
        start_win(8'd0);
        capture(8'd0, 2, 0, 0);
        wait_win("extreme");
        chk("extreme_bytes", tx_cnt, 5 * DEPTH);
        chk("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
